// File: rtl/clkrst_seq.sv
// -----------------------------------------------------------------------------
// clkrst_seq
//
// Clock-enable and reset sequencer placed behind the board PLL wrapper.
// Qualifies the PLL lock indication, keeps every downstream channel in reset
// until lock has been stable for LOCK_CYCLES cycles, then releases the
// per-channel resets one after another, STAGGER cycles apart. A released
// channel receives a clock-enable strobe every div_i cycles. Losing lock
// re-asserts every reset and bumps a saturating debug counter.
//
// Optional feature macro: CLKRST_SEQ_LOCK_SYNC_EN
//   defined     -> pll_locked passes through a two-flop synchroniser
//                  (adds two cycles to lock acquisition and lock-loss response)
//   not defined -> pll_locked is used directly as the qualified lock
//
// Parameters:
//   NUM_CH       number of channels (1..4)
//   DIV_W        width of one divisor field
//   DIVS         packed divisors, channel i at [i*DIV_W +: DIV_W]; 0 acts as 1
//   LOCK_CYCLES  qualified-lock cycles needed before the first release (>=1)
//   STAGGER      cycles between successive channel releases (>=1)
//
// Ports:
//   clock       in   PLL output clock, sole clock
//   reset       in   synchronous, active-high reset
//   pll_locked  in   raw PLL lock indicator (may be asynchronous)
//   rst_out     out  per-channel reset, active-high
//   ce          out  per-channel clock-enable strobe
//   ready       out  high once every channel is released
//   lock_loss   out  saturating count of lock losses after release began
// -----------------------------------------------------------------------------
module clkrst_seq #(
    parameter int                       NUM_CH      = 3,
    parameter int                       DIV_W       = 8,
    parameter logic [NUM_CH*DIV_W-1:0]  DIVS        = {8'd1, 8'd2, 8'd4},
    parameter int                       LOCK_CYCLES = 1024,
    parameter int                       STAGGER     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pll_locked,
    output logic [NUM_CH-1:0] rst_out,
    output logic [NUM_CH-1:0] ce,
    output logic              ready,
    output logic [7:0]        lock_loss
);

    // One counter serves both the lock-stability count and the stagger count,
    // so it must hold the larger of the two limits.
    localparam int CNT_MAX = (LOCK_CYCLES > STAGGER) ? LOCK_CYCLES : STAGGER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] STAG_LIMIT = CNT_W'(STAGGER);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [NUM_CH-1:0]  r_rst_out;
    logic [NUM_CH-1:0]  w_rst_nxt;
    logic               r_ready;
    logic               w_ready_nxt;
    logic [7:0]         r_lock_loss;
    logic [7:0]         w_ll_nxt;
    logic               w_drop;
    logic               w_lk;

    // -------------------------------------------------------------------------
    // Lock qualification
    // -------------------------------------------------------------------------
`ifdef CLKRST_SEQ_LOCK_SYNC_EN
    logic [1:0] r_lock_sync;

    // Two-flop synchroniser for the asynchronous PLL lock indicator.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lock_sync <= 2'b00;
        end else begin
            r_lock_sync <= {r_lock_sync[0], pll_locked};
        end
    end

    assign w_lk = r_lock_sync[1];
`else
    assign w_lk = pll_locked;
`endif

    // -------------------------------------------------------------------------
    // Sequencer FSM
    // -------------------------------------------------------------------------

    // Next-state, counter, release mask, ready and lock-loss computation.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_nxt   = r_rst_out;
        w_ready_nxt = r_ready;
        w_ll_nxt    = r_lock_loss;
        w_drop      = 1'b0;

        case (r_state)
            WAIT_LOCK: begin
                w_rst_nxt   = {NUM_CH{1'b1}};
                w_ready_nxt = 1'b0;
                w_idx_nxt   = '0;
                if (w_lk) begin
                    // The sampling edge itself is the first stable cycle.
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end

            STABLE: begin
                if (!w_lk) begin
                    // Glitch before release: restart quietly, not counted.
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LOCK_LIMIT) begin
                    w_state_nxt  = RELEASE;
                    w_cnt_nxt    = CNT_ONE;
                    w_idx_nxt    = '0;
                    w_rst_nxt[0] = 1'b0;
                    // With a single channel the first release is the last one.
                    w_ready_nxt  = (NUM_CH == 1);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            RELEASE: begin
                if (!w_lk) begin
                    w_drop = 1'b1;
                end else if (r_idx == LAST_IDX) begin
                    // All channels are out of reset; settle into RUN.
                    w_state_nxt = RUN;
                end else if (r_cnt == STAG_LIMIT) begin
                    w_idx_nxt   = r_idx + IDX_ONE;
                    w_cnt_nxt   = CNT_ONE;
                    w_ready_nxt = ((r_idx + IDX_ONE) == LAST_IDX);
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (c == (int'(r_idx) + 1)) begin
                            w_rst_nxt[c] = 1'b0;
                        end else begin
                            w_rst_nxt[c] = r_rst_out[c];
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            RUN: begin
                if (!w_lk) begin
                    w_drop = 1'b1;
                end else begin
                    w_state_nxt = RUN;
                end
            end

            default: begin
                w_state_nxt = WAIT_LOCK;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_rst_nxt   = {NUM_CH{1'b1}};
                w_ready_nxt = 1'b0;
            end
        endcase

        // Lock lost after release began: full re-entry into reset, counted.
        if (w_drop) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_rst_nxt   = {NUM_CH{1'b1}};
            w_ready_nxt = 1'b0;
            w_ll_nxt    = (r_lock_loss == 8'hFF) ? r_lock_loss
                                                 : (r_lock_loss + 8'd1);
        end else begin
            w_ll_nxt    = r_lock_loss;
        end
    end

    // FSM state, counters and registered control outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_out   <= {NUM_CH{1'b1}};
            r_ready     <= 1'b0;
            r_lock_loss <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_rst_out   <= w_rst_nxt;
            r_ready     <= w_ready_nxt;
            r_lock_loss <= w_ll_nxt;
        end
    end

    assign rst_out   = r_rst_out;
    assign ready     = r_ready;
    assign lock_loss = r_lock_loss;

    // -------------------------------------------------------------------------
    // Per-channel clock-enable dividers
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [DIV_W-1:0] DIV_RAW  = DIVS[g*DIV_W +: DIV_W];
        // A zero divisor behaves like a divisor of one.
        localparam logic [DIV_W-1:0] DIV_LAST = (DIV_RAW == '0) ? '0
                                              : (DIV_RAW - DIV_W'(1));

        logic [DIV_W-1:0] r_div_cnt;
        logic [DIV_W-1:0] w_div_nxt;
        logic             r_ce;
        logic             w_ce_nxt;

        // Divider count: pinned to zero while this channel is (or is about
        // to be) in reset, so it always starts from zero on release.
        always_comb begin
            if (r_rst_out[g] || w_rst_nxt[g]) begin
                w_div_nxt = '0;
            end else if (r_div_cnt == DIV_LAST) begin
                w_div_nxt = '0;
            end else begin
                w_div_nxt = r_div_cnt + DIV_W'(1);
            end
            // Registered strobe, timed as if decoded from the divider state.
            w_ce_nxt = (!w_rst_nxt[g]) && (w_div_nxt == DIV_LAST);
        end

        // Divider counter and strobe registers.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_div_cnt <= '0;
                r_ce      <= 1'b0;
            end else begin
                r_div_cnt <= w_div_nxt;
                r_ce      <= w_ce_nxt;
            end
        end

        assign ce[g] = r_ce;
    end

endmodule

// File: tb/tb_clkrst_seq.sv
module tb_clkrst_seq;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 8;
    localparam int LOCK_CYCLES = 16;
    localparam int STAGGER     = 8;
    localparam logic [NUM_CH*DIV_W-1:0] DIVS = {8'd1, 8'd2, 8'd4};
`ifdef CLKRST_SEQ_LOCK_SYNC_EN
    localparam int SYNC_D = 2;
`else
    localparam int SYNC_D = 0;
`endif

    // Channel divisors as the test plan states them: ch0=4, ch1=2, ch2=1.
    int div_tab [NUM_CH] = '{4, 2, 1};

    logic              clock      = 1'b0;
    logic              reset      = 1'b1;
    logic              pll_locked = 1'b0;
    logic [NUM_CH-1:0] rst_out;
    logic [NUM_CH-1:0] ce;
    logic              ready;
    logic [7:0]        lock_loss;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state: length of the current run of qualified-lock
    // samples, the saturating drop count, and the lock delay line.
    int run_len = 0;
    int ll_cnt  = 0;
    bit dly [2];

    clkrst_seq #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DIVS        (DIVS),
        .LOCK_CYCLES (LOCK_CYCLES),
        .STAGGER     (STAGGER)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pll_locked (pll_locked),
        .rst_out    (rst_out),
        .ce         (ce),
        .ready      (ready),
        .lock_loss  (lock_loss)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Model one clock edge: channel i is released once the lock run has
    // lasted LOCK_CYCLES+1+i*STAGGER samples; a drop counts once release began.
    task automatic model_edge(input bit rst_v, input bit pl_v);
        bit lk;
        if (rst_v) begin
            run_len = 0;
            ll_cnt  = 0;
            dly[0]  = 1'b0;
            dly[1]  = 1'b0;
        end else begin
            if (SYNC_D == 2) begin
                lk     = dly[1];
                dly[1] = dly[0];
                dly[0] = pl_v;
            end else begin
                lk = pl_v;
            end
            if (lk) begin
                run_len++;
            end else begin
                if (run_len >= LOCK_CYCLES + 1 && ll_cnt < 255) ll_cnt++;
                run_len = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] exp_rst;
        logic [NUM_CH-1:0] exp_ce;
        int thr;
        int off;
        for (int i = 0; i < NUM_CH; i++) begin
            thr = LOCK_CYCLES + 1 + i * STAGGER;
            off = run_len - thr;
            exp_rst[i] = (run_len < thr);
            exp_ce[i]  = (off >= 0) && ((off % div_tab[i]) == div_tab[i] - 1);
        end
        check_val("rst_out",   32'(rst_out),   32'(exp_rst));
        check_val("ce",        32'(ce),        32'(exp_ce));
        check_val("ready",     32'(ready),
                  32'(run_len >= LOCK_CYCLES + 1 + (NUM_CH - 1) * STAGGER));
        check_val("lock_loss", 32'(lock_loss), 32'(ll_cnt));
    endtask

    task automatic cycle(input bit rst_v, input bit pl_v);
        reset      = rst_v;
        pll_locked = pl_v;
        @(posedge clock);
        model_edge(rst_v, pl_v);
        @(negedge clock);
        cyc++;
        check_outputs();
    endtask

    initial begin
        bit pl;

        // Reset, then a long idle period without lock.
        repeat (3) cycle(1'b1, 1'b0);
        repeat (100) cycle(1'b0, 1'b0);

        // Clean lock: full staggered release and divided strobes.
        repeat (60) cycle(1'b0, 1'b1);

        // Lock drop while running, then relock through the whole sequence.
        repeat (4) cycle(1'b0, 1'b0);
        repeat (10) cycle(1'b0, 1'b1);
        // One-cycle glitch while still counting stability.
        cycle(1'b0, 1'b0);
        repeat (60) cycle(1'b0, 1'b1);
        check_val("relock_ready", 32'(ready), 32'd1);

        // Many drops after release to drive the debug counter into saturation.
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(LOCK_CYCLES + 1 + SYNC_D, LOCK_CYCLES + 40))
                cycle(1'b0, 1'b1);
            repeat ($urandom_range(1, 3)) cycle(1'b0, 1'b0);
        end
        check_val("lock_loss_sat", 32'(lock_loss), 32'd255);

        // Reset asserted in the middle of the release stagger.
        repeat (2) cycle(1'b1, 1'b0);
        repeat (SYNC_D + LOCK_CYCLES + 4) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        check_val("mid_release_rst", 32'(rst_out), 32'h7);
        check_val("mid_release_ll",  32'(lock_loss), 32'd0);

        // Random lock behaviour with occasional resets.
        pl = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 29) == 0) pl = ~pl;
            cycle($urandom_range(0, 299) == 0, pl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clkrst_seq.md
# clkrst_seq

Parametrised clock-enable and reset sequencer sitting directly behind the board PLL wrapper. It qualifies the PLL lock signal, holds every downstream domain in reset until lock has been stable for a programmable time, and releases per-channel resets in a fixed staggered order. Once released, each channel gets a divided clock-enable strobe. Everything runs on the PLL output clock; lock loss re-enters reset and is counted for debug.

## Interface
- NUM_CH, 3: number of channels, 1..4.
- DIV_W, 8: width of one divisor field.
- DIVS, {8'd1,8'd2,8'd4}: packed NUM_CH*DIV_W divisors; channel i uses bits [i*DIV_W +: DIV_W]; value 0 is treated as 1.
- LOCK_CYCLES, 1024: consecutive qualified-lock cycles required before the first release; must be ≥1.
- STAGGER, 16: cycles between successive channel releases; must be ≥1.

Ports:
- clock  in  1  PLL output clock; sole clock.
- reset  in  1  synchronous, active-high.
- pll_locked  in  1  raw PLL lock indicator; may be asynchronous.
- rst_out  out  NUM_CH  per-channel reset, active-high.
- ce  out  NUM_CH  per-channel clock-enable strobe.
- ready  out  1  high when all channels are released.
- lock_loss  out  8  saturating lock-loss counter.

## Operation
- Qualified lock `lk` is pll_locked, or its synchronised copy (see Configuration).
- FSM states: WAIT_LOCK, STABLE, RELEASE, RUN.
- WAIT_LOCK: stable counter = 0. When lk=1, go to STABLE with counter = 1.
- STABLE: counter increments while lk=1. When the counter reaches LOCK_CYCLES, go to RELEASE with channel index 0.
- RELEASE: on entry, rst_out[0] clears. Every STAGGER cycles, the next channel index clears. After rst_out[NUM_CH-1] clears, go to RUN.
- RUN: ready=1; steady state.
- lk=0 in STABLE, RELEASE or RUN returns to WAIT_LOCK on the next edge and sets all rst_out=1, ce=0, ready=0.
- lock_loss increments only on drops from RELEASE or RUN, and saturates at 255. A drop from STABLE does not count.
- Per-channel divider, counter width DIV_W:
  - Held at 0 while rst_out[i]=1.
  - Otherwise ce[i]=1 when counter == div_i-1, and the counter wraps to 0; else it increments.
  - div_i=1 gives ce[i] constantly 1 while released.
  - ce[i] is combinational from registered state, or registered with equal timing; it is never high while rst_out[i]=1.
- reset, from any state: WAIT_LOCK, all counters 0, rst_out all 1, ce 0, ready 0, lock_loss 0.

## Timing
- Reset values: rst_out={NUM_CH{1}}, ce=0, ready=0, lock_loss=0.
- Let L be the first edge at which lk=1 is sampled. This is 2 edges after pll_locked rises with the synchroniser, 0 without.
- rst_out[0] falls at edge L+LOCK_CYCLES.
- rst_out[i] falls at edge L+LOCK_CYCLES+i*STAGGER.
- ready rises at the same edge as rst_out[NUM_CH-1] falls.
- First ce[i] pulse: the cycle after rst_out[i] falls plus div_i-1 cycles. After that, one pulse every div_i cycles.
- Lock loss: the edge sampling lk=0 asserts all rst_out, drops ready, and bumps lock_loss. Its visibility lags pll_locked by the synchroniser depth.
- lk glitching low for one cycle in STABLE restarts the full LOCK_CYCLES count.
- NUM_CH=1: RELEASE lasts exactly one cycle, then RUN.

## Configuration
- CLKRST_SEQ_LOCK_SYNC_EN defined:
  - pll_locked passes through a two-flop synchroniser, reset to 0, giving lk.
  - Adds 2 cycles to both lock acquisition and lock-loss response.
- Not defined:
  - lk = pll_locked directly, for simulation or an already-synchronous lock source.
  - No added latency.

## Test plan
All scenarios use NUM_CH=3, DIVS={1,2,4} (ch0=4, ch1=2, ch2=1), LOCK_CYCLES=16, STAGGER=8, synchroniser enabled, unless stated.

- Reset with pll_locked=0 for 100 cycles -> rst_out=3'b111, ce=0, ready=0, lock_loss=0 throughout.
- pll_locked rises at edge 0 -> rst_out[0] falls at edge 18, rst_out[1] at 26, rst_out[2] and ready at 34.
  - ce[0] pulses every 4 cycles, first at cycle 21.
  - ce[1] every 2 cycles.
  - ce[2] constantly 1 from cycle 34.
- pll_locked low for 1 cycle at edge 10 (in STABLE) -> count restarts; rst_out[0] falls 16 cycles after lk returns high; lock_loss stays 0.
- pll_locked drops in RUN -> 2 edges later all rst_out=1, ce=0, ready=0, lock_loss=1. Relock repeats the full release sequence.
- 300 lock drops in RUN -> lock_loss saturates at 255 and never wraps.
- Synchroniser macro undefined, pll_locked rises at edge 0 -> rst_out[0] falls at edge 16; assert reset mid-RELEASE -> all outputs return to reset values on the next edge.
